// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and helpers for the round-robin lock arbiter (package arb_pkg).
// Default MAX_HOLD here is only used when ARB_TIMEOUT_EN is defined.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_HOLD_DEFAULT = 16;
  localparam int ARB_MAX_PORTS        = 16;

  function automatic logic [ARB_MAX_PORTS-1:0] onehot(input logic [3:0] idx);
    onehot = 16'd1 << idx;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between requesters (master) and rr_lock_arbiter (slave).
// timeout_o exists only when ARB_TIMEOUT_EN is defined.
interface rr_lock_arbiter_if #(
  parameter  int NUM_PORTS = 4,
  localparam int IDX_W     = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS-1:0] req_i;
  logic                 release_i;
  logic [NUM_PORTS-1:0] gnt_o;
  logic                 gnt_valid_o;
  logic [IDX_W-1:0]     gnt_idx_o;
`ifdef ARB_TIMEOUT_EN
  logic                 timeout_o;

  modport master (output req_i, output release_i,
                  input gnt_o, input gnt_valid_o, input gnt_idx_o, input timeout_o);
  modport slave  (input req_i, input release_i,
                  output gnt_o, output gnt_valid_o, output gnt_idx_o, output timeout_o);
`else
  modport master (output req_i, output release_i,
                  input gnt_o, input gnt_valid_o, input gnt_idx_o);
  modport slave  (input req_i, input release_i,
                  output gnt_o, output gnt_valid_o, output gnt_idx_o);
`endif
endinterface

// File: rtl/rr_lock_arbiter_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr_i,
// wrapping around. Reusable by any arbiter that keeps its own pointer.
module rr_pick #(
  parameter  int NUM_PORTS = 4,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [NUM_PORTS-1:0] rot_s;
  logic [IDX_W-1:0]     off_s;
  logic [IDX_W:0]       sum_s;

  // Doubling the vector makes the shift a rotation: bit 0 of rot_s is port ptr_i.
  assign rot_s   = NUM_PORTS'({req_i, req_i} >> ptr_i);
  assign valid_o = |req_i;
  assign sum_s   = {1'b0, ptr_i} + {1'b0, off_s};

  // Fixed-priority pick on the rotated vector; lowest offset wins.
  always_comb begin
    off_s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = IDX_W'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  // Map the offset back to an absolute port number modulo NUM_PORTS.
  always_comb begin
    if (sum_s >= (IDX_W+1)'(NUM_PORTS)) begin
      idx_o = IDX_W'(sum_s - (IDX_W+1)'(NUM_PORTS));
    end else begin
      idx_o = IDX_W'(sum_s);
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Registered round-robin arbiter with grant locking and a mandatory idle cycle
// between grants. Define ARB_TIMEOUT_EN to force-release grants after MAX_HOLD cycles.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
`endif
) (
  input logic               clk,
  input logic               rst_n,
  rr_lock_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e           state_q;
  logic [NUM_PORTS-1:0] gnt_q;
  logic                 gnt_valid_q;
  logic [IDX_W-1:0]     gnt_idx_q;
  logic [IDX_W-1:0]     ptr_q;

  logic                 pick_valid_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic [NUM_PORTS-1:0] pick_gnt_s;
  logic [IDX_W-1:0]     ptr_d;
  logic                 normal_end_s;
  logic                 end_s;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req_i   (bus.req_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid_s),
    .idx_o   (pick_idx_s)
  );

  assign pick_gnt_s   = NUM_PORTS'(onehot(4'(pick_idx_s)));
  assign ptr_d        = (gnt_idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
  assign normal_end_s = bus.release_i | ~bus.req_i[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  logic       timeout_q;
  logic       timeout_hit_s;

  // A normal release in the same cycle wins over the timeout.
  assign timeout_hit_s = ~normal_end_s & (hold_q == 8'(MAX_HOLD - 1));
  assign end_s         = normal_end_s | timeout_hit_s;
  assign bus.timeout_o = timeout_q;
`else
  assign end_s = normal_end_s;
`endif

  // Arbitration FSM, rotating pointer and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= 8'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_valid_s) begin
            state_q     <= BUSY;
            gnt_q       <= pick_gnt_s;
            gnt_valid_q <= 1'b1;
            gnt_idx_q   <= pick_idx_s;
`ifdef ARB_TIMEOUT_EN
            hold_q      <= 8'd0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          // Going back to IDLE for one cycle gives the resource its turnaround.
          if (end_s) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            timeout_q   <= timeout_hit_s;
`endif
          end else begin
            state_q <= BUSY;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_q + 8'd1;
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_valid_o = gnt_valid_q;
  assign bus.gnt_idx_o   = gnt_idx_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter: directed vector table, hand-written
// reset/timeout sequences, and random traffic against a behavioural model.
module tb_rr_lock_arbiter;

  localparam int N = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
  localparam int LOCK_CYC    = 2;
`else
  localparam int LOCK_CYC    = 10;
`endif

  typedef struct {
    logic [N-1:0] req;
    logic         rel;
    logic [N-1:0] gnt;
    logic         vld;
    logic [1:0]   idx;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  rr_lock_arbiter_if #(.NUM_PORTS(N)) bus ();

`ifdef ARB_TIMEOUT_EN
  rr_lock_arbiter #(.NUM_PORTS(N), .MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`else
  rr_lock_arbiter #(.NUM_PORTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: who owns the resource, how long, and the rotation point.
  int m_ptr;
  int m_idx;
  bit m_busy;
  int m_held;
  bit m_to;

  function automatic void model_reset();
    m_ptr  = 0;
    m_idx  = 0;
    m_busy = 0;
    m_held = 0;
    m_to   = 0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] req, input logic rel);
    bit found;
    int p;
    m_to = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (!found && req[p]) begin
          found = 1;
          m_idx = p;
        end
      end
      if (found) begin
        m_busy = 1;
        m_held = 0;
      end
    end else begin
      m_held++;
      if (rel || !req[m_idx]) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % N;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_held == TB_MAX_HOLD) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % N;
        m_to   = 1;
      end
`endif
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(bus.req_i, bus.release_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_i     = '0;
    bus.release_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(bus.gnt_o), 32'd0);
    chk("reset_vld", 32'(bus.gnt_valid_o), 32'd0);
    chk("reset_idx", 32'(bus.gnt_idx_o), 32'd0);
`ifdef ARB_TIMEOUT_EN
    chk("reset_to", 32'(bus.timeout_o), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void add(input logic [N-1:0] req, input logic rel,
                              input logic [N-1:0] gnt, input logic vld, input logic [1:0] idx);
    vec_t v;
    v.req = req; v.rel = rel; v.gnt = gnt; v.vld = vld; v.idx = idx;
    vecs.push_back(v);
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Directed table: inputs applied before an edge, outputs expected after it.
    add(4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1);
    add(4'b1010, 1'b1, 4'b0000, 1'b0, 2'd1);
    add(4'b1011, 1'b0, 4'b1000, 1'b1, 2'd3);
    add(4'b1011, 1'b1, 4'b0000, 1'b0, 2'd3);
    add(4'b1011, 1'b0, 4'b0001, 1'b1, 2'd0);
    add(4'b1011, 1'b1, 4'b0000, 1'b0, 2'd0);
    add(4'b1011, 1'b0, 4'b0010, 1'b1, 2'd1);
    add(4'b1011, 1'b1, 4'b0000, 1'b0, 2'd1);
    add(4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0);
    for (int i = 0; i < LOCK_CYC; i++) add(4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0);
    add(4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0);
    add(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2);
    add(4'b1000, 1'b0, 4'b0000, 1'b0, 2'd2);
    add(4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3);
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3);
    add(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3);

    do_reset();
    foreach (vecs[i]) begin
      bus.req_i     = vecs[i].req;
      bus.release_i = vecs[i].rel;
      step();
      chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt_o), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d_vld", i), 32'(bus.gnt_valid_o), 32'(vecs[i].vld));
      chk($sformatf("vec%0d_idx", i), 32'(bus.gnt_idx_o), 32'(vecs[i].idx));
    end

    // Async reset in the middle of a grant clears the grant without a clock edge.
    do_reset();
    bus.req_i = 4'b0100;
    step();
    chk("pre_rst_gnt", 32'(bus.gnt_o), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("async_rst_vld", 32'(bus.gnt_valid_o), 32'd0);
    chk("async_rst_idx", 32'(bus.gnt_idx_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    bus.req_i = 4'b1000;
    step();
    chk("post_rst_gnt", 32'(bus.gnt_o), 32'h8);
    chk("post_rst_idx", 32'(bus.gnt_idx_o), 32'd3);

    // Pointer back at 0 after reset: with everyone requesting, port 0 wins.
    do_reset();
    bus.req_i = 4'b1111;
    step();
    chk("ptr0_gnt", 32'(bus.gnt_o), 32'h1);

`ifdef ARB_TIMEOUT_EN
    // Timeout: port 1 held without release is forced off after MAX_HOLD cycles.
    do_reset();
    bus.req_i = 4'b0110;
    for (int i = 0; i < TB_MAX_HOLD; i++) begin
      step();
      chk($sformatf("hold%0d_gnt", i), 32'(bus.gnt_o), 32'h2);
      chk($sformatf("hold%0d_to", i), 32'(bus.timeout_o), 32'd0);
    end
    step();
    chk("to_gnt", 32'(bus.gnt_o), 32'h0);
    chk("to_pulse", 32'(bus.timeout_o), 32'd1);
    step();
    chk("to_next_gnt", 32'(bus.gnt_o), 32'h4);
    chk("to_pulse_end", 32'(bus.timeout_o), 32'd0);
    for (int i = 1; i < TB_MAX_HOLD; i++) step();
    bus.release_i = 1'b1;
    step();
    chk("rel_wins_gnt", 32'(bus.gnt_o), 32'h0);
    chk("rel_wins_to", 32'(bus.timeout_o), 32'd0);
    bus.release_i = 1'b0;
`endif

    // Random traffic against the behavioural model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req_i = N'($urandom_range(0, 15));
      bus.release_i = ($urandom_range(0, 4) == 0);
      step();
      chk("rnd_gnt", 32'(bus.gnt_o), m_busy ? (32'd1 << m_idx) : 32'd0);
      chk("rnd_vld", 32'(bus.gnt_valid_o), 32'(m_busy));
      chk("rnd_idx", 32'(bus.gnt_idx_o), 32'(m_idx));
`ifdef ARB_TIMEOUT_EN
      chk("rnd_to", 32'(bus.timeout_o), 32'(m_to));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
